// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: framer states, the default
// bit period for the 100 MHz board clock, and the frame-length helper.
package uart_pkg;

    // Framer states, in the order they occur on the line.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int unsigned SYS_CLK_HZ           = 100_000_000;
    localparam int unsigned DEFAULT_BAUD         = 115_200;
    // 100 MHz / 115200 baud rounds down to 868 clocks per bit.
    localparam int unsigned DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / DEFAULT_BAUD;

    // Clock cycles from the cycle after the accepting edge to the end of
    // the last stop bit: start bit, payload bits and stop bits.
    function automatic int unsigned frame_cycles(
        input int unsigned clks_per_bit,
        input int unsigned data_bits,
        input int unsigned stop_bits
    );
        return (1 + data_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Emits a single-cycle tick every CLKS_PER_BIT cycles,
// with the count phase-aligned to the cycle after restart is last seen.
// The count is reloaded at every tick, so no error builds up across bits.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic RST,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // The tick marks the final cycle of a bit period; it is suppressed
    // while the counter is being held in restart.
    assign tick = !restart && (cnt_q == LAST_CNT);

    // Free-running period counter, cleared by restart and at each boundary.
    always_ff @(posedge clk or posedge RST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its inputs from before the edge, independent of code order.
        if (RST) begin
            cnt_q <= '0;
        end else if (restart || (cnt_q == LAST_CNT)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmitter: accepts one word per valid/ready transfer and sends it
// LSB first as a start bit, DATA_BITS payload bits and STOP_BITS stop bits.
// The line output comes straight from a flop so it never glitches, and an
// asynchronous reset drives it high immediately, abandoning any frame.
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 busy
);

    // Three bits cover both the payload index (up to 7) and the stop index.
    localparam logic [2:0] LAST_DATA_IDX = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP_IDX = 3'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 tx_q, tx_d;
    logic                 transfer;
    logic                 restart;
    logic                 bit_tick;

    assign s_ready  = (state_q == IDLE);
    assign busy     = ~s_ready;
    assign tx       = tx_q;
    assign transfer = s_valid && s_ready;

    // Holding the timer in restart while idle means the first bit period
    // starts counting in the cycle right after the accepting edge.
    assign restart = (state_q == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk     (clk),
        .RST     (RST),
        .restart (restart),
        .tick    (bit_tick)
    );

    // Next-state logic: sequencing, shift register and next line level.
    always_comb begin
        // NOTE: every signal assigned here first gets a default (hold value),
        // so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        tx_d      = tx_q;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (transfer) begin
                    state_d   = START;
                    shift_d   = s_data;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end

            DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_DATA_IDX) begin
                        state_d   = STOP;
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[1];
                    end
                end
            end

            STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, shift register and line flop; reset forces the line idle-high.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            // NOTE: the shift register is reset along with the control state;
            // it is only a few flops and keeps simulation free of X payloads.
            shift_q   <= '0;
            bit_idx_q <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

endmodule
